// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the A09 memory arbiter: owner encodings, streak width
// and the streak update rule.
package mem_arbiter_pkg;

  localparam int unsigned STREAK_W = 4;
  typedef logic [STREAK_W-1:0] streak_t;
  localparam streak_t STREAK_MAX = '1;

  // In-flight owner encodings
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

  // Bit positions inside the one-hot grant vector
  localparam int unsigned GNT_CPU = 0;
  localparam int unsigned GNT_LDR = 1;

  // Streak counts CPU grants taken while the loader waits; any loader grant
  // or an idle loader clears it, and it saturates instead of wrapping.
  function automatic streak_t streak_next(streak_t cur, logic cpu_gnt,
                                          logic ldr_gnt, logic ldr_req);
    if (ldr_gnt || !ldr_req) return '0;
    if (cpu_gnt && (cur != STREAK_MAX)) return cur + streak_t'(1);
    return cur;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory command/response signals of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_data_i;
  logic                  cpu_gnt_o;
  logic                  cpu_rvalid_o;
  logic [DATA_WIDTH-1:0] cpu_data_o;

  logic                  ldr_req_i;
  logic                  ldr_we_i;
  logic [ADDR_WIDTH-1:0] ldr_addr_i;
  logic [DATA_WIDTH-1:0] ldr_data_i;
  logic                  ldr_gnt_o;
  logic                  ldr_rvalid_o;
  logic [DATA_WIDTH-1:0] ldr_data_o;
  logic                  ldr_lock_i;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  busy_o;

  // Arbiter side
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  ldr_req_i, ldr_we_i, ldr_addr_i, ldr_data_i, ldr_lock_i,
    input  mem_data_i,
    output cpu_gnt_o, cpu_rvalid_o, cpu_data_o,
    output ldr_gnt_o, ldr_rvalid_o, ldr_data_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_data_o, busy_o
  );

  // Requesters and memory side
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output ldr_req_i, ldr_we_i, ldr_addr_i, ldr_data_i, ldr_lock_i,
    output mem_data_i,
    input  cpu_gnt_o, cpu_rvalid_o, cpu_data_o,
    input  ldr_gnt_o, ldr_rvalid_o, ldr_data_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o, busy_o
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between CPU and loader.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic    cpu_req_i,
  input  logic    ldr_req_i,
  input  logic    lock_i,
  input  streak_t streak_i,
  output logic [1:0] gnt_o
);
  localparam streak_t HOLD_LIM = streak_t'(HOLD_MAX);

  // Lock first, then streak-limited CPU priority, else the lone requester
  always_comb begin
    gnt_o = '0;
    if (lock_i) begin
      gnt_o[GNT_LDR] = ldr_req_i;
    end else if (cpu_req_i && ldr_req_i) begin
      if (streak_i < HOLD_LIM) gnt_o[GNT_CPU] = 1'b1;
      else                     gnt_o[GNT_LDR] = 1'b1;
    end else begin
      gnt_o[GNT_CPU] = cpu_req_i;
      gnt_o[GNT_LDR] = ldr_req_i;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the A09 single-port memory between the CPU and the program loader.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned HOLD_MAX   = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  mem_arbiter_if.slave bus
);
  logic [1:0] gnt;
  logic       cpu_gnt;
  logic       ldr_gnt;
  streak_t    streak_q, streak_d;
  logic [1:0] owner_q, owner_d;
  logic       rd_q, rd_d;

  mem_arb_pick #(.HOLD_MAX(HOLD_MAX)) u_pick (
    .cpu_req_i (bus.cpu_req_i),
    .ldr_req_i (bus.ldr_req_i),
    .lock_i    (bus.ldr_lock_i),
    .streak_i  (streak_q),
    .gnt_o     (gnt)
  );

  // Grants are masked during reset so the command bus is idle while held
  assign cpu_gnt = gnt[GNT_CPU] & reset_ni;
  assign ldr_gnt = gnt[GNT_LDR] & reset_ni;

  // Drive the memory command bus from the granted requester
  always_comb begin
    bus.cpu_gnt_o  = cpu_gnt;
    bus.ldr_gnt_o  = ldr_gnt;
    bus.mem_en_o   = cpu_gnt | ldr_gnt;
    bus.mem_we_o   = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;
    if (cpu_gnt) begin
      bus.mem_we_o   = bus.cpu_we_i;
      bus.mem_addr_o = bus.cpu_addr_i;
      bus.mem_data_o = bus.cpu_data_i;
    end else if (ldr_gnt) begin
      bus.mem_we_o   = bus.ldr_we_i;
      bus.mem_addr_o = bus.ldr_addr_i;
      bus.mem_data_o = bus.ldr_data_i;
    end
  end

  // Next owner, read flag and streak from this cycle's grant
  always_comb begin
    owner_d = OWN_NONE;
    rd_d    = 1'b0;
    if (cpu_gnt) begin
      owner_d = OWN_CPU;
      rd_d    = ~bus.cpu_we_i;
    end else if (ldr_gnt) begin
      owner_d = OWN_LDR;
      rd_d    = ~bus.ldr_we_i;
    end
    streak_d = streak_next(streak_q, cpu_gnt, ldr_gnt, bus.ldr_req_i);
  end

  // In-flight and starvation state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      owner_q  <= OWN_NONE;
      rd_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      rd_q     <= rd_d;
      streak_q <= streak_d;
    end
  end

  // Route returning read data to the owner of the in-flight read
  always_comb begin
    bus.cpu_rvalid_o = rd_q && (owner_q == OWN_CPU);
    bus.ldr_rvalid_o = rd_q && (owner_q == OWN_LDR);
    bus.cpu_data_o   = bus.cpu_rvalid_o ? bus.mem_data_i : '0;
    bus.ldr_data_o   = bus.ldr_rvalid_o ? bus.mem_data_i : '0;
    bus.busy_o       = rd_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural reference plus directed scenarios.
module tb_mem_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOLD_MAX(HOLD)) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: single-port, read data one cycle after the strobe
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16) return 16'h1234;
    return 16'hA000 | 16'(a);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
  end

  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_data_o;
      else              bus.mem_data_i     <= mem[bus.mem_addr_o];
    end
  end

  // Reference model: pending read kind (0 none, 1 cpu, 2 loader), its address,
  // and the count of CPU wins while the loader is waiting.
  int m_streak = 0;
  int m_pend   = 0;
  int m_paddr  = 0;
  logic e_c, e_l, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd;

  always @(negedge clk) begin
    if (!reset_ni) begin
      m_streak = 0;
      m_pend   = 0;
      check("rst_cpu_gnt",    bus.cpu_gnt_o,    0);
      check("rst_ldr_gnt",    bus.ldr_gnt_o,    0);
      check("rst_mem_en",     bus.mem_en_o,     0);
      check("rst_mem_we",     bus.mem_we_o,     0);
      check("rst_mem_addr",   bus.mem_addr_o,   0);
      check("rst_mem_data",   bus.mem_data_o,   0);
      check("rst_cpu_rvalid", bus.cpu_rvalid_o, 0);
      check("rst_ldr_rvalid", bus.ldr_rvalid_o, 0);
      check("rst_cpu_data",   bus.cpu_data_o,   0);
      check("rst_ldr_data",   bus.ldr_data_o,   0);
      check("rst_busy",       bus.busy_o,       0);
    end else begin
      e_c = 1'b0;
      e_l = 1'b0;
      if (bus.ldr_lock_i) e_l = bus.ldr_req_i;
      else if (bus.cpu_req_i && bus.ldr_req_i) begin
        if (m_streak < HOLD) e_c = 1'b1;
        else                 e_l = 1'b1;
      end else begin
        e_c = bus.cpu_req_i;
        e_l = bus.ldr_req_i;
      end
      e_we   = e_c ? bus.cpu_we_i   : (e_l ? bus.ldr_we_i   : 1'b0);
      e_addr = e_c ? bus.cpu_addr_i : (e_l ? bus.ldr_addr_i : '0);
      e_wd   = e_c ? bus.cpu_data_i : (e_l ? bus.ldr_data_i : '0);
      check("cpu_gnt",  bus.cpu_gnt_o,  e_c);
      check("ldr_gnt",  bus.ldr_gnt_o,  e_l);
      check("mem_en",   bus.mem_en_o,   e_c | e_l);
      check("mem_we",   bus.mem_we_o,   e_we);
      check("mem_addr", bus.mem_addr_o, e_addr);
      check("mem_data", bus.mem_data_o, e_wd);

      e_rd = ref_mem[m_paddr];
      check("cpu_rvalid", bus.cpu_rvalid_o, m_pend == 1);
      check("ldr_rvalid", bus.ldr_rvalid_o, m_pend == 2);
      check("cpu_data",   bus.cpu_data_o,   (m_pend == 1) ? e_rd : '0);
      check("ldr_data",   bus.ldr_data_o,   (m_pend == 2) ? e_rd : '0);
      check("busy",       bus.busy_o,       m_pend != 0);

      // Advance to the state after the coming rising edge
      if (e_c || e_l) begin
        if (e_we) ref_mem[e_addr] = e_wd;
        m_pend  = e_we ? 0 : (e_c ? 1 : 2);
        m_paddr = int'(e_addr);
      end else begin
        m_pend = 0;
      end
      if (e_l || !bus.ldr_req_i) m_streak = 0;
      else if (e_c && m_streak < 15) m_streak++;
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic lr, input logic lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic lk);
    bus.cpu_req_i  = cr;
    bus.cpu_we_i   = cw;
    bus.cpu_addr_i = ca;
    bus.cpu_data_i = cd;
    bus.ldr_req_i  = lr;
    bus.ldr_we_i   = lw;
    bus.ldr_addr_i = la;
    bus.ldr_data_i = ld;
    bus.ldr_lock_i = lk;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] pat10;
  logic [4:0] pat5;
  int cnt;

  initial begin
    idle();
    repeat (2) @(negedge clk);
    check("lit_reset_busy", bus.busy_o, 0);
    next_cycle();
    reset_ni = 1'b1;

    // CPU read of 0x10
    drive(1, 0, 8'h10, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    check("lit_t1_gnt",  bus.cpu_gnt_o,  1);
    check("lit_t1_addr", bus.mem_addr_o, 32'h10);
    next_cycle();
    idle();
    @(negedge clk);
    check("lit_t1_rvalid", bus.cpu_rvalid_o, 1);
    check("lit_t1_data",   bus.cpu_data_o,   32'h1234);
    check("lit_t1_ldrrv",  bus.ldr_rvalid_o, 0);
    next_cycle();

    // Continuous contention, both reading
    drive(1, 0, 8'h40, '0, 1, 0, 8'h41, '0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat10[i] = bus.cpu_gnt_o;
      next_cycle();
    end
    check("lit_t2_pattern", 32'(pat10), 32'b0111101111);
    idle();
    @(negedge clk);
    check("lit_t2_last_ldr_rv", bus.ldr_rvalid_o, 1);
    check("lit_t2_last_data",   bus.ldr_data_o,   32'hA041);
    next_cycle();

    // Loader locked write while the CPU keeps requesting
    drive(1, 0, 8'h20, '0, 1, 1, 8'h20, 16'hBEEF, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt += int'(bus.cpu_gnt_o);
      if (i == 0) check("lit_t3_ldr_gnt", bus.ldr_gnt_o, 1);
      next_cycle();
      bus.ldr_req_i = 1'b0;
      bus.ldr_we_i  = 1'b0;
    end
    check("lit_t3_no_cpu_gnt", cnt, 0);
    bus.ldr_lock_i = 1'b0;
    @(negedge clk);
    check("lit_t3_cpu_gnt", bus.cpu_gnt_o, 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("lit_t3_data", bus.cpu_data_o, 32'hBEEF);
    next_cycle();

    // Lock raised while a CPU read is in flight
    drive(1, 0, 8'h10, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    check("lit_t4_gnt", bus.cpu_gnt_o, 1);
    next_cycle();
    drive(1, 0, 8'h11, '0, 0, 0, '0, '0, 1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("lit_t4_rvalid", bus.cpu_rvalid_o, 1);
        check("lit_t4_data",   bus.cpu_data_o,   32'h1234);
      end
      cnt += int'(bus.cpu_gnt_o);
      next_cycle();
    end
    check("lit_t4_no_gnt", cnt, 0);
    idle();
    next_cycle();

    // Reset pulse right after a loader read grant
    drive(0, 0, '0, '0, 1, 0, 8'h10, '0, 0);
    @(negedge clk);
    check("lit_t5_ldr_gnt", bus.ldr_gnt_o, 1);
    @(posedge clk);
    #1;
    idle();
    #1;
    reset_ni = 1'b0;
    #1;
    check("lit_t5_busy_now",   bus.busy_o,       0);
    check("lit_t5_ldrrv_now",  bus.ldr_rvalid_o, 0);
    @(negedge clk);
    check("lit_t5_ldrrv", bus.ldr_rvalid_o, 0);
    next_cycle();
    reset_ni = 1'b1;
    @(negedge clk);
    check("lit_t5_after_rv", bus.ldr_rvalid_o, 0);
    next_cycle();
    drive(1, 0, 8'h40, '0, 1, 0, 8'h41, '0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pat5[i] = bus.cpu_gnt_o;
      next_cycle();
    end
    check("lit_t5_pattern", 32'(pat5), 32'b01111);
    idle();
    next_cycle();

    // Back-to-back write then read of 0x05
    drive(1, 1, 8'h05, 16'h00AA, 0, 0, '0, '0, 0);
    @(negedge clk);
    check("lit_t6_wr_gnt", bus.cpu_gnt_o, 1);
    check("lit_t6_wr_we",  bus.mem_we_o,  1);
    next_cycle();
    drive(1, 0, 8'h05, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    check("lit_t6_no_wr_rv", bus.cpu_rvalid_o, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("lit_t6_rvalid", bus.cpu_rvalid_o, 1);
    check("lit_t6_data",   bus.cpu_data_o,   32'h00AA);
    next_cycle();
    repeat (2) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
